// File: rtl/jogo_seq_param.sv
`default_nettype none
// ============================================================================
//  Module      : jogo_seq_param
//  Description : Parametrised PlaySeq sequence-memory game engine.
//                Each round the player records one more step (GRAVA), the
//                core replays the whole sequence on the LEDs, then checks the
//                player's repetition press by press.
//  Ports       : clock     - system clock
//                reset     - asynchronous, active-high reset
//                jogar     - start/restart request (INICIAL or FIM_* only)
//                botoes    - button levels, already synchronised
//                tamanho   - target length minus 1, latched on start
//                modo_auto - (JOGO_SEQ_LFSR_EN only) LFSR records the steps
//                leds      - LED drive (replay / echo of buttons)
//                ganhou, perdeu, timeout - end-of-game flags
//                pronto    - game finished
//                rodada    - current round index
//                db_estado - FSM state code
//  Options     : define JOGO_SEQ_LFSR_EN to add modo_auto and the LFSR.
//  Revision    : 1.0 - initial release
// ============================================================================
module jogo_seq_param #(
    parameter int N_BOTOES  = 4,
    parameter int PROF      = 16,
    parameter int T_LED     = 1000,
    parameter int T_APAGADO = 250,
    parameter int T_TIMEOUT = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    jogar,
    input  logic [N_BOTOES-1:0]     botoes,
    input  logic [$clog2(PROF)-1:0] tamanho,
`ifdef JOGO_SEQ_LFSR_EN
    input  logic                    modo_auto,
`endif
    output logic [N_BOTOES-1:0]     leds,
    output logic                    ganhou,
    output logic                    perdeu,
    output logic                    timeout,
    output logic                    pronto,
    output logic [$clog2(PROF)-1:0] rodada,
    output logic [3:0]              db_estado
);

    localparam int RW   = $clog2(PROF);
    localparam int BW   = $clog2(N_BOTOES);
    localparam int TMAX = (T_LED > T_APAGADO)
                        ? ((T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT)
                        : ((T_APAGADO > T_TIMEOUT) ? T_APAGADO : T_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        GRAVA          = 4'd2,
        MOSTRA_ACESO   = 4'd3,
        MOSTRA_APAGADO = 4'd4,
        ESPERA         = 4'd5,
        COMPARA        = 4'd6,
        PROX_JOGADA    = 4'd7,
        PROX_RODADA    = 4'd8,
        FIM_GANHOU     = 4'd9,
        FIM_PERDEU     = 4'd10,
        FIM_TIMEOUT    = 4'd11
    } estado_t;

    estado_t            estado, prox_estado;
    logic [N_BOTOES-1:0] botoes_d;
    logic [BW-1:0]      mem [PROF];
    logic [BW-1:0]      press_idx;
    logic [RW-1:0]      r, idx, len;
    logic [TW-1:0]      tmr;

    logic               press_ev, press_ok, tmr_fim;
    logic [BW-1:0]      press_idx_w, wr_dado;
    logic               ld_len, ini, wr_mem, inc_r, clr_idx, inc_idx, clr_tmr;

    // Index of the highest set bit; only meaningful for one-hot inputs.
    function automatic logic [BW-1:0] codifica(input logic [N_BOTOES-1:0] v);
        logic [BW-1:0] k;
        k = '0;
        for (int i = 0; i < N_BOTOES; i++)
            if (v[i]) k = BW'(i);
        return k;
    endfunction

    // A press is the first cycle any button is seen after all were released,
    // so a held button never re-triggers.
    assign press_ev    = (botoes != '0) && (botoes_d == '0);
    assign press_ok    = press_ev && ((botoes & (botoes - N_BOTOES'(1))) == '0);
    assign press_idx_w = codifica(botoes);
    assign tmr_fim     = (tmr == TW'(T_TIMEOUT - 1));

`ifdef JOGO_SEQ_LFSR_EN
    logic [15:0]   lfsr;
    logic [BW-1:0] auto_dado;
    // 5-bit dividend so N_BOTOES=16 is representable as a modulus.
    assign auto_dado = BW'({1'b0, lfsr[3:0]} % 5'(N_BOTOES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    // Next state and datapath strobes.
    always_comb begin
        prox_estado = estado;
        ld_len      = 1'b0;
        ini         = 1'b0;
        wr_mem      = 1'b0;
        wr_dado     = press_idx_w;
        inc_r       = 1'b0;
        clr_idx     = 1'b0;
        inc_idx     = 1'b0;
        case (estado)
            INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                if (jogar) begin
                    prox_estado = PREPARA;
                    ld_len      = 1'b1;
                end
            end
            PREPARA: begin
                ini         = 1'b1;
                prox_estado = GRAVA;
            end
            GRAVA: begin
`ifdef JOGO_SEQ_LFSR_EN
                if (modo_auto) begin
                    wr_mem      = 1'b1;
                    wr_dado     = auto_dado;
                    clr_idx     = 1'b1;
                    prox_estado = MOSTRA_ACESO;
                end else
`endif
                if (press_ok) begin
                    wr_mem      = 1'b1;
                    clr_idx     = 1'b1;
                    prox_estado = MOSTRA_ACESO;
                end else if (!press_ev && tmr_fim) begin
                    prox_estado = FIM_TIMEOUT;
                end
            end
            MOSTRA_ACESO: begin
                if (tmr == TW'(T_LED - 1)) prox_estado = MOSTRA_APAGADO;
            end
            MOSTRA_APAGADO: begin
                if (tmr == TW'(T_APAGADO - 1)) begin
                    if (idx == r) begin
                        clr_idx     = 1'b1;
                        prox_estado = ESPERA;
                    end else begin
                        inc_idx     = 1'b1;
                        prox_estado = MOSTRA_ACESO;
                    end
                end
            end
            ESPERA: begin
                if (press_ev)     prox_estado = press_ok ? COMPARA : FIM_PERDEU;
                else if (tmr_fim) prox_estado = FIM_TIMEOUT;
            end
            COMPARA: begin
                if (mem[idx] != press_idx) prox_estado = FIM_PERDEU;
                else if (idx != r)         prox_estado = PROX_JOGADA;
                else if (r == len)         prox_estado = FIM_GANHOU;
                else                       prox_estado = PROX_RODADA;
            end
            PROX_JOGADA: begin
                inc_idx     = 1'b1;
                prox_estado = ESPERA;
            end
            PROX_RODADA: begin
                inc_r       = 1'b1;
                prox_estado = GRAVA;
            end
            default: prox_estado = INICIAL;
        endcase
        // One shared timer: restarts on every state change and on any press
        // while waiting for the player.
        clr_tmr = (prox_estado != estado) ||
                  (press_ev && ((estado == GRAVA) || (estado == ESPERA)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= INICIAL;
            botoes_d  <= '0;
            press_idx <= '0;
            r         <= '0;
            idx       <= '0;
            len       <= '0;
            tmr       <= '0;
        end else begin
            estado   <= prox_estado;
            botoes_d <= botoes;
            if (press_ev) press_idx <= press_idx_w;
            if (ld_len)   len <= tamanho;
            if (ini)        r <= '0;
            else if (inc_r) r <= r + RW'(1);
            if (ini || clr_idx) idx <= '0;
            else if (inc_idx)   idx <= idx + RW'(1);
            tmr <= clr_tmr ? '0 : tmr + TW'(1);
        end
    end

    // Sequence storage: no reset, contents are defined by GRAVA writes.
    always_ff @(posedge clock) begin
        if (wr_mem) mem[r] <= wr_dado;
    end

    always_comb begin
        leds = '0;
        case (estado)
            MOSTRA_ACESO: leds = N_BOTOES'(1) << mem[idx];
            ESPERA:       leds = botoes;
            default:      leds = '0;
        endcase
    end

    assign ganhou    = (estado == FIM_GANHOU);
    assign perdeu    = (estado == FIM_PERDEU);
    assign timeout   = (estado == FIM_TIMEOUT);
    assign pronto    = ganhou || perdeu || timeout;
    assign rodada    = r;
    assign db_estado = estado;

endmodule
`default_nettype wire

// File: tb/tb_jogo_seq_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jogo_seq_param
//  Description : Directed self-checking bench for jogo_seq_param
//                (N_BOTOES=4, PROF=4, T_LED=4, T_APAGADO=2, T_TIMEOUT=20).
//                Honours JOGO_SEQ_LFSR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jogo_seq_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic [3:0] botoes;
    logic [1:0] tamanho;
    logic [3:0] leds;
    logic       ganhou, perdeu, timeout, pronto;
    logic [1:0] rodada;
    logic [3:0] db_estado;
`ifdef JOGO_SEQ_LFSR_EN
    logic       modo_auto;
`endif

    int tests  = 0;
    int failed = 0;

    jogo_seq_param #(
        .N_BOTOES (4),
        .PROF     (4),
        .T_LED    (4),
        .T_APAGADO(2),
        .T_TIMEOUT(20)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .jogar    (jogar),
        .botoes   (botoes),
        .tamanho  (tamanho),
`ifdef JOGO_SEQ_LFSR_EN
        .modo_auto(modo_auto),
`endif
        .leds     (leds),
        .ganhou   (ganhou),
        .perdeu   (perdeu),
        .timeout  (timeout),
        .pronto   (pronto),
        .rodada   (rodada),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic flags(input string tag, input logic g, input logic p, input logic t);
        check({tag, "_ganhou"},  ganhou,  g);
        check({tag, "_perdeu"},  perdeu,  p);
        check({tag, "_timeout"}, timeout, t);
        check({tag, "_pronto"},  pronto,  g | p | t);
    endtask

    task automatic start(input logic [1:0] tam);
        jogar = 1'b1; tamanho = tam;
        tick(1);
        check("start_prepara", db_estado, 4'd1);
        flags("start_prepara", 1'b0, 1'b0, 1'b0);
        jogar = 1'b0;
        tick(1);
        check("start_grava", db_estado, 4'd2);
        check("start_rodada", rodada, 2'd0);
    endtask

    // Expects to be called on the first MOSTRA_ACESO cycle; nibble s of seq
    // is the LED pattern of step s. Ends on the first ESPERA cycle.
    task automatic replay(input int n, input logic [15:0] seq);
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("replay%0d_on%0d_state", s, k), db_estado, 4'd3);
                check($sformatf("replay%0d_on%0d_leds", s, k), leds, seq[s*4 +: 4]);
                tick(1);
            end
            for (int k = 0; k < 2; k++) begin
                check($sformatf("replay%0d_off%0d_state", s, k), db_estado, 4'd4);
                check($sformatf("replay%0d_off%0d_leds", s, k), leds, 4'd0);
                tick(1);
            end
        end
        check("replay_end_espera", db_estado, 4'd5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; jogar = 1'b0; botoes = 4'd0; tamanho = 2'd0;
`ifdef JOGO_SEQ_LFSR_EN
        modo_auto = 1'b0;
`endif
        tick(2);
        check("reset_state", db_estado, 4'd0);
        check("reset_leds", leds, 4'd0);
        check("reset_rodada", rodada, 2'd0);
        flags("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1);
        check("idle_state", db_estado, 4'd0);

        // 1) two-round win
        start(2'd1);
        botoes = 4'b0010; tick(1); botoes = 4'b0000;
        replay(1, 16'h0002);
        botoes = 4'b0010; tick(1);
        check("t1_r0_compara", db_estado, 4'd6);
        botoes = 4'b0000; tick(1);
        check("t1_prox_rodada", db_estado, 4'd8);
        tick(1);
        check("t1_grava2", db_estado, 4'd2);
        check("t1_rodada1", rodada, 2'd1);
        botoes = 4'b1000; tick(1); botoes = 4'b0000;
        replay(2, 16'h0082);
        botoes = 4'b0010; tick(1);
        check("t1_c0", db_estado, 4'd6);
        botoes = 4'b0000; tick(1);
        check("t1_prox_jogada", db_estado, 4'd7);
        tick(1);
        check("t1_espera2", db_estado, 4'd5);
        botoes = 4'b1000; tick(1);
        check("t1_c1", db_estado, 4'd6);
        check("t1_ganhou_t1", ganhou, 1'b0);
        botoes = 4'b0000; tick(1);
        check("t1_fim_state", db_estado, 4'd9);
        flags("t1_fim", 1'b1, 1'b0, 1'b0);
        check("t1_fim_leds", leds, 4'd0);
        check("t1_fim_rodada", rodada, 2'd1);

        // 2) wrong press
        jogar = 1'b1; tamanho = 2'd2; tick(1);
        check("t2_prepara", db_estado, 4'd1);
        flags("t2_prepara", 1'b0, 1'b0, 1'b0);
        jogar = 1'b0; tick(1);
        check("t2_grava", db_estado, 4'd2);
        botoes = 4'b0001; tick(1); botoes = 4'b0000;
        replay(1, 16'h0001);
        botoes = 4'b0100; tick(1);
        check("t2_compara", db_estado, 4'd6);
        check("t2_perdeu_t1", perdeu, 1'b0);
        botoes = 4'b0000; tick(1);
        check("t2_fim_state", db_estado, 4'd10);
        flags("t2_fim", 1'b0, 1'b1, 1'b0);
        check("t2_rodada", rodada, 2'd0);

        // 3) timeout in ESPERA
        start(2'd1);
        botoes = 4'b0100; tick(1); botoes = 4'b0000;
        replay(1, 16'h0004);
        tick(19);
        check("t3_still_espera", db_estado, 4'd5);
        check("t3_no_timeout_yet", timeout, 1'b0);
        tick(1);
        check("t3_fim_state", db_estado, 4'd11);
        flags("t3_fim", 1'b0, 1'b0, 1'b1);
        start(2'd1);

        // 4) multi-bit presses
        botoes = 4'b0011; tick(1);
        check("t4_grava_multi", db_estado, 4'd2);
        botoes = 4'b0000; tick(1);
        check("t4_grava_stays", db_estado, 4'd2);
        botoes = 4'b0001; tick(1); botoes = 4'b0000;
        replay(1, 16'h0001);
        botoes = 4'b0011; tick(1);
        check("t4_espera_multi", db_estado, 4'd10);
        flags("t4_fim", 1'b0, 1'b1, 1'b0);
        botoes = 4'b0000;

        // 5) held button through replay does not count as a press
        start(2'd1);
        botoes = 4'b0100; tick(1);
        replay(1, 16'h0004);
        check("t5_echo", leds, 4'b0100);
        tick(3);
        check("t5_held_no_press", db_estado, 4'd5);
        botoes = 4'b0000; tick(1);
        check("t5_released", db_estado, 4'd5);
        botoes = 4'b0100; tick(1);
        check("t5_repress", db_estado, 4'd6);
        botoes = 4'b0000; tick(1);
        check("t5_prox_rodada", db_estado, 4'd8);
        tick(1);
        check("t5_grava", db_estado, 4'd2);
        check("t5_rodada", rodada, 2'd1);

        // 6) asynchronous reset during replay
        botoes = 4'b0001; tick(1);
        check("t6_mostra", db_estado, 4'd3);
        check("t6_mostra_leds", leds, 4'b0100);
        botoes = 4'b0000; tick(1);
        check("t6_mostra2", db_estado, 4'd3);
        #1 reset = 1'b1;
        #1;
        check("t6_reset_state", db_estado, 4'd0);
        check("t6_reset_leds", leds, 4'd0);
        check("t6_reset_rodada", rodada, 2'd0);
        flags("t6_reset", 1'b0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("t6_after_reset", db_estado, 4'd0);

`ifdef JOGO_SEQ_LFSR_EN
        modo_auto = 1'b1;
        start(2'd1);
        tick(1);
        check("auto_grava_one_cycle", db_estado, 4'd3);
        check("auto_leds_onehot", {31'd0, $onehot(leds)}, 32'd1);
        modo_auto = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
